// File: rtl/exibe_sequencia_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exibe_sequencia_pkg
// Description : State codes shared by the presenter and its debug decoding.
// Revision    : 1.0 - initial release
// ============================================================================
package exibe_sequencia_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL = 4'd0,
        ST_PREPARA = 4'd1,
        ST_BUSCA   = 4'd2,
        ST_CARREGA = 4'd3,
        ST_ACENDE  = 4'd4,
        ST_APAGA   = 4'd5,
        ST_PROXIMO = 4'd6,
        ST_FIM     = 4'd15
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/exibe_sequencia_if.sv
`default_nettype none
// ============================================================================
// Module      : exibe_sequencia_if
// Description : Control, ROM and display signals between the presenter and
//               the top-level controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface exibe_sequencia_if;

    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] dado_memoria;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    modport master (
        output iniciar, limite, dado_memoria,
        input  endereco, leds, ocupado, pronto, db_estado
    );

    modport slave (
        input  iniciar, limite, dado_memoria,
        output endereco, leds, ocupado, pronto, db_estado
    );

endinterface
`default_nettype wire

// File: rtl/exibe_sequencia_contador_tempo.sv
`default_nettype none
// ============================================================================
// Module      : exibe_sequencia_contador_tempo
// Description : Clear/enable up-counter with a terminal-value compare pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module exibe_sequencia_contador_tempo #(
    parameter int W_T = 10
) (
    input  wire logic           clock,
    input  wire logic           reset,
    input  wire logic           i_limpa,
    input  wire logic           i_habilita,
    input  wire logic [W_T-1:0] i_valor_final,
    output logic                o_fim
);

    logic [W_T-1:0] r_contagem;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_contagem <= '0;
        end else if (i_limpa) begin
            r_contagem <= '0;
        end else if (i_habilita) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    assign o_fim = i_habilita && (r_contagem == i_valor_final);

endmodule
`default_nettype wire

// File: rtl/exibe_sequencia.sv
`default_nettype none
// ============================================================================
// Module      : exibe_sequencia
// Description : Plays ROM items 0..limite on the leds, each lit for T_ON
//               cycles and followed by T_OFF dark cycles, then pulses pronto.
// Revision    : 1.0 - initial release
// ============================================================================
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int T_ON  = 1000,
    parameter int T_OFF = 500,
    parameter int W_T   = 10
) (
    input wire logic          clock,
    input wire logic          reset,
    exibe_sequencia_if.slave  bus
);

    estado_t        r_estado;
    logic [3:0]     r_endereco;
    logic [3:0]     r_leds;
    logic           r_ocupado;
    logic           r_pronto;

    logic           w_fim;
    logic           w_limpa;
    logic           w_habilita;
    logic [W_T-1:0] w_valor_final;

    // Timer restarts on entry to ACENDE and again on every terminal pulse.
    assign w_habilita    = (r_estado == ST_ACENDE) || (r_estado == ST_APAGA);
    assign w_limpa       = (r_estado == ST_CARREGA) || w_fim;
    assign w_valor_final = (r_estado == ST_ACENDE) ? W_T'(T_ON - 1) : W_T'(T_OFF - 1);

    exibe_sequencia_contador_tempo #(
        .W_T (W_T)
    ) u_contador_tempo (
        .clock         (clock),
        .reset         (reset),
        .i_limpa       (w_limpa),
        .i_habilita    (w_habilita),
        .i_valor_final (w_valor_final),
        .o_fim         (w_fim)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado   <= ST_INICIAL;
            r_endereco <= 4'd0;
            r_leds     <= 4'd0;
            r_ocupado  <= 1'b0;
            r_pronto   <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                ST_INICIAL: begin
                    if (bus.iniciar) begin
                        r_estado   <= ST_PREPARA;
                        r_endereco <= 4'd0;
                        r_ocupado  <= 1'b1;
                    end
                end
                ST_PREPARA: r_estado <= ST_BUSCA;
                ST_BUSCA:   r_estado <= ST_CARREGA;
                ST_CARREGA: begin
                    r_leds   <= bus.dado_memoria;
                    r_estado <= ST_ACENDE;
                end
                ST_ACENDE: begin
                    if (w_fim) begin
                        r_leds   <= 4'd0;
                        r_estado <= ST_APAGA;
                    end
                end
                ST_APAGA: begin
                    if (w_fim) begin
                        r_estado <= ST_PROXIMO;
                    end
                end
                ST_PROXIMO: begin
                    // Last address is held so endereco never wraps to 0.
                    if (r_endereco == bus.limite) begin
                        r_estado <= ST_FIM;
                        r_pronto <= 1'b1;
                    end else begin
                        r_endereco <= r_endereco + 4'd1;
                        r_estado   <= ST_BUSCA;
                    end
                end
                ST_FIM: begin
                    r_estado  <= ST_INICIAL;
                    r_ocupado <= 1'b0;
                end
                default: begin
                    r_estado  <= ST_INICIAL;
                    r_leds    <= 4'd0;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign bus.endereco  = r_endereco;
    assign bus.leds      = r_leds;
    assign bus.ocupado   = r_ocupado;
    assign bus.pronto    = r_pronto;
    assign bus.db_estado = r_estado;

endmodule
`default_nettype wire
